spi_buffer_scheduler: RTL

SPI_BUFFER_SCHEDULER -- requirements
Module: spi_buffer_scheduler

---
 rtl/spi_buffer_scheduler.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/spi_buffer_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : spi_buffer_scheduler
//  Brief    : Ping-pong word buffer between an SPI byte stream and a CPU port;
//             the CPU swaps banks between frames via a flip request.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_buffer_scheduler #(
    parameter int DATA_WIDTH     = 32,
    parameter int SPI_DATA_WIDTH = 8,
    parameter int BUF_SIZE       = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          spi_ready,
    input  logic                          spi_cs,
    input  logic [SPI_DATA_WIDTH-1:0]     spi_data_in,
    output logic [SPI_DATA_WIDTH-1:0]     spi_data_out,
    input  logic                          cpu_wr,
    input  logic                          cpu_rd,
    input  logic [$clog2(BUF_SIZE)-1:0]   cpu_addr,
    input  logic [DATA_WIDTH-1:0]         cpu_data_in,
    output logic [DATA_WIDTH-1:0]         cpu_data_out,
    input  logic                          flip,
    output logic                          swapped,
    output logic                          overflow,
    output logic [$clog2(BUF_SIZE+1)-1:0] words_rx
);

    localparam int c_BPW = DATA_WIDTH / SPI_DATA_WIDTH;
    localparam int c_BCW = (c_BPW > 1) ? $clog2(c_BPW) : 1;
    localparam int c_AW  = $clog2(BUF_SIZE + 1);
    localparam int c_IW  = $clog2(BUF_SIZE);
    localparam logic [c_BCW-1:0] c_LAST_BYTE = c_BCW'(c_BPW - 1);
    localparam logic [c_AW-1:0]  c_WORDS     = c_AW'(BUF_SIZE);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FRAME     = 2'd1,
        WAIT_FLIP = 2'd2,
        SWAP      = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic                    r_bank_sel;
    logic                    r_flip_pend;
    logic                    r_ready_q;
    logic [c_BCW-1:0]        r_byte_cnt;
    logic [c_AW-1:0]         r_word_addr;
    logic [DATA_WIDTH-1:0]   r_asm;
    logic                    r_wr_pend;
    logic [DATA_WIDTH-1:0]   r_tx;
    logic                    r_overflow;
    logic                    r_swapped;
    logic [DATA_WIDTH-1:0]   r_cpu_rdata;
    logic [DATA_WIDTH-1:0]   r_mem [0:1][0:BUF_SIZE-1];

    logic                    w_byte_evt;
    logic                    w_word_room;
    logic                    w_cpu_addr_ok;
    logic [DATA_WIDTH-1:0]   w_asm_next;
    logic [DATA_WIDTH-1:0]   w_tx_word;

    assign w_byte_evt    = spi_ready & ~r_ready_q;
    assign w_word_room   = (r_word_addr < c_WORDS);
    assign w_cpu_addr_ok = (c_AW'(cpu_addr) < c_WORDS);
    assign w_asm_next    = (r_asm << SPI_DATA_WIDTH) | DATA_WIDTH'(spi_data_in);
    assign w_tx_word     = w_word_room ? r_mem[r_bank_sel][r_word_addr[c_IW-1:0]] : '0;

    assign spi_data_out  = (r_state == FRAME) ? r_tx[DATA_WIDTH-1 -: SPI_DATA_WIDTH] : '0;
    assign cpu_data_out  = r_cpu_rdata;
    assign swapped       = r_swapped;
    assign overflow      = r_overflow;
    assign words_rx      = r_word_addr;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:      if (spi_cs) w_state_next = FRAME;
            FRAME:     if (!spi_cs) w_state_next = WAIT_FLIP;
            WAIT_FLIP: begin
                if (spi_cs)           w_state_next = FRAME;
                else if (r_flip_pend) w_state_next = SWAP;
            end
            SWAP:      w_state_next = IDLE;
            default:   w_state_next = IDLE;
        endcase
    end

    // The SPI side only ever touches bank r_bank_sel, the CPU side only its complement.
    always_ff @(posedge clk) begin
        if (r_wr_pend && w_word_room)
            r_mem[r_bank_sel][r_word_addr[c_IW-1:0]] <= r_asm;
        if (cpu_wr && w_cpu_addr_ok)
            r_mem[~r_bank_sel][cpu_addr] <= cpu_data_in;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_bank_sel  <= 1'b0;
            r_flip_pend <= 1'b0;
            r_ready_q   <= 1'b0;
            r_byte_cnt  <= '0;
            r_word_addr <= '0;
            r_asm       <= '0;
            r_wr_pend   <= 1'b0;
            r_tx        <= '0;
            r_overflow  <= 1'b0;
            r_swapped   <= 1'b0;
            r_cpu_rdata <= '0;
        end else begin
            r_state   <= w_state_next;
            r_ready_q <= spi_ready;
            r_swapped <= (r_state == SWAP);

            if (flip)
                r_flip_pend <= 1'b1;
            else if (w_state_next == SWAP && r_state != SWAP)
                r_flip_pend <= 1'b0;

            if (cpu_rd)
                r_cpu_rdata <= w_cpu_addr_ok ? r_mem[~r_bank_sel][cpu_addr] : '0;

            if (r_state == SWAP) begin
                r_bank_sel  <= ~r_bank_sel;
                r_byte_cnt  <= '0;
                r_word_addr <= '0;
                r_overflow  <= 1'b0;
                r_wr_pend   <= 1'b0;
            end else if (r_state == WAIT_FLIP && spi_cs) begin
                r_byte_cnt  <= '0;
                r_word_addr <= '0;
                r_wr_pend   <= 1'b0;
            end else begin
                // Completed word commits one edge after its last byte arrives.
                if (r_wr_pend) begin
                    r_wr_pend <= 1'b0;
                    if (w_word_room)
                        r_word_addr <= r_word_addr + c_AW'(1);
                    else
                        r_overflow <= 1'b1;
                end
                if (r_state == FRAME && w_byte_evt) begin
                    r_asm <= w_asm_next;
                    if (r_byte_cnt == c_LAST_BYTE) begin
                        r_byte_cnt <= '0;
                        r_wr_pend  <= 1'b1;
                    end else begin
                        r_byte_cnt <= r_byte_cnt + c_BCW'(1);
                    end
                end else if (r_state != FRAME) begin
                    r_byte_cnt <= '0;
                end
            end

            // Transmit word is refreshed while idle between words so byte 0 is ready early.
            if (r_state == FRAME && w_byte_evt)
                r_tx <= r_tx << SPI_DATA_WIDTH;
            else if (r_byte_cnt == '0 && !r_wr_pend)
                r_tx <= w_tx_word;
        end
    end

endmodule
`default_nettype wire
